// File: rtl/sa_col_ctrl.sv
// sa_col_ctrl: systolic column sequencer (run, drain capture, result replay); SA_COL_CTRL_PERF_EN adds perf counters
module sa_col_ctrl #(
  parameter int LEN_W    = 8,
  parameter int DRAIN_TO = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [127:0]     op_data,
  input  logic [7:0]       op_weight,
  output logic             col_fire_in,
  output logic [127:0]     col_data_in,
  output logic [7:0]       col_weight_in,
  input  logic [31:0]      col_result,
  input  logic             col_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_last,
  output logic             err
`ifdef SA_COL_CTRL_PERF_EN
  ,
  output logic [15:0]      perf_cycles,
  output logic [15:0]      perf_bubbles
`endif
);
  localparam int TO_W = $clog2(DRAIN_TO + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;
  state_t state, state_nxt;
  logic [LEN_W-1:0] rem;
  logic [4:0] wptr, rptr;
  logic [TO_W-1:0] tcnt;
  logic [31:0] buffer [16];
  logic job_acc, beat, cap, fill_done, drain_fail, out_done;
  assign job_acc = (state == IDLE) && job_valid;
  assign beat = (state == RUN) && op_valid;
  assign cap = (state == DRAIN) && col_valid && !wptr[4];
  assign fill_done = cap && (wptr == 5'd15);
  assign drain_fail = (state == DRAIN) && !fill_done && (tcnt == TO_W'(DRAIN_TO));
  assign out_done = (state == OUT) && res_ready && (rptr == 5'd15);
  // next state and state-decoded handshake outputs
  always_comb begin
    state_nxt = state;
    job_ready = 1'b0;
    op_ready = 1'b0;
    res_valid = 1'b0;
    res_last = 1'b0;
    res_data = '0;
    unique case (state)
      IDLE: begin
        job_ready = 1'b1;
        state_nxt = (job_valid && job_len != '0) ? RUN : IDLE;
      end
      RUN: begin
        op_ready = 1'b1;
        state_nxt = (op_valid && rem == LEN_W'(1)) ? DRAIN : RUN;
      end
      DRAIN: state_nxt = fill_done ? OUT : drain_fail ? IDLE : DRAIN;
      OUT: begin
        res_valid = 1'b1;
        res_data = buffer[rptr[3:0]];
        res_last = rptr == 5'd15;
        state_nxt = out_done ? IDLE : OUT;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // column drive: fire follows RUN by one cycle so it lines up with the registered beat; stalls become zero products
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_fire_in <= 1'b0;
      col_data_in <= '0;
      col_weight_in <= '0;
    end else begin
      col_fire_in <= state == RUN;
      col_data_in <= beat ? op_data : '0;
      col_weight_in <= beat ? op_weight : '0;
    end
  // beat countdown and sticky error (zero-length job or drain timeout)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem <= '0;
      err <= 1'b0;
    end else if (job_acc) begin
      rem <= job_len;
      err <= job_len == '0;
    end else begin
      rem <= beat ? rem - LEN_W'(1) : rem;
      err <= err | drain_fail;
    end
  // drain capture into the result buffer with timeout count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      tcnt <= '0;
      for (int i = 0; i < 16; i++) buffer[i] <= '0;
    end else if (state == RUN && state_nxt == DRAIN) begin
      wptr <= '0;
      tcnt <= '0;
      for (int i = 0; i < 16; i++) buffer[i] <= '0;
    end else if (state == DRAIN) begin
      tcnt <= tcnt + TO_W'(1);
      if (cap) begin
        buffer[wptr[3:0]] <= col_result;
        wptr <= wptr + 5'd1;
      end
    end
  // replay pointer, rewound when the buffer fills
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rptr <= '0;
    else if (fill_done) rptr <= '0;
    else if (res_valid && res_ready) rptr <= rptr + 5'd1;
`ifdef SA_COL_CTRL_PERF_EN
  logic [15:0] cyc, bub;
  // per-job cycle and bubble counters, published on every return to IDLE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cyc <= '0;
      bub <= '0;
      perf_cycles <= '0;
      perf_bubbles <= '0;
    end else begin
      cyc <= job_acc ? '0 : (state != IDLE && cyc != 16'hFFFF) ? cyc + 16'd1 : cyc;
      bub <= job_acc ? '0 : (state == RUN && !op_valid && bub != 16'hFFFF) ? bub + 16'd1 : bub;
      if (job_acc && job_len == '0) begin
        perf_cycles <= '0;
        perf_bubbles <= '0;
      end else if (state != IDLE && state_nxt == IDLE) begin
        perf_cycles <= (cyc == 16'hFFFF) ? cyc : cyc + 16'd1;
        perf_bubbles <= bub;
      end
    end
`endif
endmodule
